// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage access controller for a 3-stage RV32 pipeline.
// Decodes the load/store held in the M-stage register, runs one req/ack
// transaction on the data bus, stalls the pipeline while it is outstanding,
// and returns aligned, extended load data.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   valid_m, opcode_m,       M-stage instruction: valid, opcode, func3,
//   func3_m, alu_out_m,      effective address and store data (rs2)
//   write_data_m
//   dbus_req_o, dbus_we_o,   data bus request, direction, word address,
//   dbus_addr_o, dbus_be_o,  byte enables and lane-replicated store data
//   dbus_wdata_o
//   dbus_ack_i, dbus_err_i,  bus completion, error qualifier, read data
//   dbus_rdata_i
//   stall_o                  freeze all pipeline registers
//   load_data_o              aligned, sign/zero-extended load result
//   misalign_o               pulse: misaligned address or illegal func3
//   bus_err_o                pulse (in DONE): ack returned with error
//   timeout_o                pulse (in DONE): access abandoned, no ack
module mem_stage_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_m,
    input  logic [6:0]        opcode_m,
    input  logic [2:0]        func3_m,
    input  logic [DW-1:0]     alu_out_m,
    input  logic [DW-1:0]     write_data_m,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [DW-1:0]     dbus_addr_o,
    output logic [DW/8-1:0]   dbus_be_o,
    output logic [DW-1:0]     dbus_wdata_o,
    input  logic              dbus_ack_i,
    input  logic              dbus_err_i,
    input  logic [DW-1:0]     dbus_rdata_i,
    output logic              stall_o,
    output logic [DW-1:0]     load_data_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              timeout_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Select the addressed lane and extend it according to func3.
    function automatic logic [DW-1:0] load_align(input logic [DW-1:0] rdata,
                                                 input logic [2:0]    f3,
                                                 input logic [1:0]    off);
        logic [DW-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_align = {{(DW-8){sh[7]}}, sh[7:0]};
            3'b001:  load_align = {{(DW-16){sh[15]}}, sh[15:0]};
            3'b100:  load_align = {{(DW-8){1'b0}}, sh[7:0]};
            3'b101:  load_align = {{(DW-16){1'b0}}, sh[15:0]};
            default: load_align = rdata;
        endcase
    endfunction

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW/8-1:0] be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [DW-1:0]   ld_q, ld_d;
    logic            berr_q, berr_d;
    logic            to_q, to_d;

    logic            is_load, is_store, mem_op, legal, aligned, start;
    logic [DW/8-1:0] be_new;
    logic [DW-1:0]   wdata_new;

    assign is_load  = (opcode_m == OP_LOAD);
    assign is_store = (opcode_m == OP_STORE);
    assign mem_op   = valid_m & (is_load | is_store);

    always_comb begin
        if (is_load)
            legal = (func3_m == 3'b000) | (func3_m == 3'b001) | (func3_m == 3'b010) |
                    (func3_m == 3'b100) | (func3_m == 3'b101);
        else
            legal = (func3_m == 3'b000) | (func3_m == 3'b001) | (func3_m == 3'b010);
    end

    // func3[1:0] encodes access size for every legal encoding.
    always_comb begin
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = write_data_m;
        case (func3_m[1:0])
            2'b00: begin
                be_new    = 4'b0001 << alu_out_m[1:0];
                wdata_new = {4{write_data_m[7:0]}};
            end
            2'b01: begin
                aligned   = ~alu_out_m[0];
                be_new    = 4'b0011 << alu_out_m[1:0];
                wdata_new = {2{write_data_m[15:0]}};
            end
            2'b10: aligned = (alu_out_m[1:0] == 2'b00);
            default: ;
        endcase
    end

    assign start = (state_q == S_IDLE) & mem_op & legal & aligned;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        ld_d    = ld_q;
        berr_d  = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    we_d    = is_store;
                    addr_d  = {alu_out_m[DW-1:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    f3_d    = func3_m;
                    off_d   = alu_out_m[1:0];
                end
            end
            S_ACCESS: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (dbus_ack_i) begin
                    state_d = S_DONE;
                    if (dbus_err_i) begin
                        ld_d   = '0;
                        berr_d = 1'b1;
                    end else if (!we_q) begin
                        ld_d = load_align(dbus_rdata_i, f3_q, off_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                        state_d = S_DONE;
                        ld_d    = '0;
                        to_d    = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            ld_q    <= '0;
            berr_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            ld_q    <= ld_d;
            berr_q  <= berr_d;
            to_q    <= to_d;
        end
    end

    // Combinational outputs are gated by reset so they fall immediately
    // even while the M-stage still presents a memory instruction.
    assign stall_o      = rst_ni & (start | (state_q == S_ACCESS));
    assign misalign_o   = rst_ni & (state_q == S_IDLE) & mem_op & ~(legal & aligned);
    assign dbus_req_o   = (state_q == S_ACCESS);
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_be_o    = be_q;
    assign dbus_wdata_o = wdata_q;
    assign load_data_o  = ld_q;
    assign bus_err_o    = berr_q;
    assign timeout_o    = to_q;

endmodule
